pure_literal_scan_ctrl: RTL and testbench

- Sequences one full pure-literal scan of a clause database through the 4-lane pure-literal detection datapath.
- Per scan:
  - synchronously clears the datapath accumulators;
  - streams clause beats (4 clauses each) from clause memory into the lanes, masking lanes past the clause count;
  - waits out the datapath pipeline, then captures the pure-literal vector and its population count.
- Sits between the DPLL top-level sequencer (start/done handshake) and the detection datapath / clause RAM.

---
 rtl/pure_literal_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pure_literal_scan_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pure_literal_scan_ctrl.sv
// pure_literal_scan_ctrl
//    Runs one pure-literal scan of a clause database through the 4-lane
//    detection datapath: clears the accumulators, streams ceil(N/4) clause
//    beats from clause memory, lets the datapath pipeline drain, then
//    captures the pure-literal vector and its population count.
//
// Ports
//    clk, reset        clock, synchronous active-high reset
//    start             scan request (only honoured in IDLE)
//    num_clauses       clause count, latched on start
//    base_addr         first beat address, latched on start
//    abort             cancel a scan in CLEAR/FETCH/DRAIN
//    busy, done        status; done is a one-cycle pulse
//    mem_rd_en/addr    clause-memory read port (1-cycle read latency)
//    mem_rd_data       beat: 4 lanes of {mask[2:0], lit2, lit1, lit0}
//    dp_clear          datapath accumulator clear
//    dp_clauses        lane literals to the datapath
//    dp_reduced        lane masks, zeroed for idle cycles and invalid lanes
//    dp_pure_literals  registered pure-literal vector from the datapath
//    result            captured pure-literal vector
//    result_valid      result belongs to a completed scan
//    pure_count        popcount of result
module pure_literal_scan_ctrl #(
   parameter int WIDTH    = 9,
   parameter int OUT_SIZE = 256,
   parameter int ADDR_W   = 10,
   parameter int CNT_W    = 12
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [CNT_W-1:0]                 num_clauses,
   input  logic [ADDR_W-1:0]                base_addr,
   input  logic                             abort,
   output logic                             busy,
   output logic                             done,
   output logic                             mem_rd_en,
   output logic [ADDR_W-1:0]                mem_rd_addr,
   input  logic [4*(3*WIDTH+3)-1:0]         mem_rd_data,
   output logic                             dp_clear,
   output logic [4*3*WIDTH-1:0]             dp_clauses,
   output logic [11:0]                      dp_reduced,
   input  logic [OUT_SIZE-1:0]              dp_pure_literals,
   output logic [OUT_SIZE-1:0]              result,
   output logic                             result_valid,
   output logic [$clog2(OUT_SIZE+1)-1:0]    pure_count
);

   localparam int LIT_W  = 3*WIDTH;
   localparam int LANE_W = 3*WIDTH + 3;
   localparam int PC_W   = $clog2(OUT_SIZE+1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_FETCH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W:0]        beats_q, beats_d;   // beats still to issue
   logic [CNT_W-1:0]      left_q,  left_d;    // clauses not yet issued
   logic [ADDR_W-1:0]     addr_q,  addr_d;
   logic [1:0]            drain_q, drain_d;
   logic [3:0]            lvld_q,  lvld_d;    // lane-valid for the beat arriving this cycle
   logic [OUT_SIZE-1:0]   result_q, result_d;
   logic [PC_W-1:0]       count_q, count_d;
   logic                  rv_q, rv_d;
   logic                  clr;

   function automatic logic [PC_W-1:0] popcount(input logic [OUT_SIZE-1:0] v);
      logic [PC_W-1:0] c;
      c = '0;
      for (int i = 0; i < OUT_SIZE; i++) begin
         c = c + PC_W'(v[i]);
      end
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         beats_q  <= '0;
         left_q   <= '0;
         addr_q   <= '0;
         drain_q  <= '0;
         lvld_q   <= '0;
         result_q <= '0;
         count_q  <= '0;
         rv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         beats_q  <= beats_d;
         left_q   <= left_d;
         addr_q   <= addr_d;
         drain_q  <= drain_d;
         lvld_q   <= lvld_d;
         result_q <= result_d;
         count_q  <= count_d;
         rv_q     <= rv_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      beats_d   = beats_q;
      left_d    = left_q;
      addr_d    = addr_q;
      drain_d   = drain_q;
      lvld_d    = '0;
      result_d  = result_q;
      count_d   = count_q;
      rv_d      = rv_q;
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd_en = 1'b0;
      clr       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // ceil(N/4) on one extra bit so N near 2^CNT_W cannot overflow
               beats_d = ({1'b0, num_clauses} + (CNT_W+1)'(3)) >> 2;
               left_d  = num_clauses;
               addr_d  = base_addr;
               drain_d = '0;
               rv_d    = 1'b0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            busy = 1'b1;
            clr  = 1'b1;
            if (abort)                 state_d = S_IDLE;
            else if (beats_q == '0)    state_d = S_DRAIN;
            else                       state_d = S_FETCH;
         end
         S_FETCH: begin
            busy = 1'b1;
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               mem_rd_en = 1'b1;
               for (int l = 0; l < 4; l++) begin
                  lvld_d[l] = (left_q > CNT_W'(l));
               end
               left_d  = (left_q > CNT_W'(4)) ? left_q - CNT_W'(4) : '0;
               addr_d  = addr_q + ADDR_W'(1);
               beats_d = beats_q - (CNT_W+1)'(1);
               if (beats_q == (CNT_W+1)'(1)) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (abort) begin
               state_d = S_IDLE;
            end else if (drain_q == 2'd2) begin
               // datapath output now reflects the last beat
               result_d = dp_pure_literals;
               count_d  = popcount(dp_pure_literals);
               rv_d     = 1'b1;
               state_d  = S_DONE;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Lane fan-out: literals pass straight through; masks are gated so the
   // accumulators only see valid lanes of a beat that was actually issued.
   always_comb begin
      dp_clauses = '0;
      dp_reduced = '0;
      for (int l = 0; l < 4; l++) begin
         dp_clauses[l*LIT_W +: LIT_W] = mem_rd_data[l*LANE_W +: LIT_W];
         dp_reduced[l*3 +: 3]         = mem_rd_data[l*LANE_W+LIT_W +: 3] & {3{lvld_q[l]}};
      end
   end

   assign dp_clear     = reset | clr;
   assign mem_rd_addr  = addr_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign pure_count   = count_q;

endmodule

// File: tb/tb_pure_literal_scan_ctrl.sv
module tb_pure_literal_scan_ctrl;

   localparam int WIDTH    = 9;
   localparam int OUT_SIZE = 256;
   localparam int ADDR_W   = 10;
   localparam int CNT_W    = 12;
   localparam int LANE_W   = 3*WIDTH + 3;
   localparam int BEAT_W   = 4*LANE_W;
   localparam int PC_W     = $clog2(OUT_SIZE+1);

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  start;
   logic [CNT_W-1:0]      num_clauses;
   logic [ADDR_W-1:0]     base_addr;
   logic                  abort;
   logic                  busy, done, mem_rd_en;
   logic [ADDR_W-1:0]     mem_rd_addr;
   logic [BEAT_W-1:0]     mem_rd_data;
   logic                  dp_clear;
   logic [4*3*WIDTH-1:0]  dp_clauses;
   logic [11:0]           dp_reduced;
   logic [OUT_SIZE-1:0]   dp_pure_literals;
   logic [OUT_SIZE-1:0]   result;
   logic                  result_valid;
   logic [PC_W-1:0]       pure_count;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pure_literal_scan_ctrl #(
      .WIDTH(WIDTH), .OUT_SIZE(OUT_SIZE), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .num_clauses(num_clauses),
      .base_addr(base_addr), .abort(abort), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .dp_clear(dp_clear), .dp_clauses(dp_clauses), .dp_reduced(dp_reduced),
      .dp_pure_literals(dp_pure_literals), .result(result),
      .result_valid(result_valid), .pure_count(pure_count)
   );

   // Clause memory: one-cycle registered read.
   logic [BEAT_W-1:0] mem [0:1023];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   // Detection datapath: literal = {negative, var[7:0]}; a variable is pure
   // when it has been seen in exactly one polarity since the last clear.
   logic [OUT_SIZE-1:0] acc_pos, acc_neg, pure_q;
   always @(posedge clk) begin : dp_model
      logic [OUT_SIZE-1:0] p, q;
      logic [WIDTH-1:0]    lit;
      p = acc_pos;
      q = acc_neg;
      for (int j = 0; j < 12; j++) begin
         if (dp_reduced[j]) begin
            lit = dp_clauses[j*WIDTH +: WIDTH];
            if (lit[8]) q[lit[7:0]] = 1'b1;
            else        p[lit[7:0]] = 1'b1;
         end
      end
      if (dp_clear) begin
         p = '0;
         q = '0;
      end
      acc_pos <= p;
      acc_neg <= q;
      pure_q  <= acc_pos ^ acc_neg;
   end
   assign dp_pure_literals = pure_q;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] lit(input int v, input int neg);
      return {1'(neg), 8'(v)};
   endfunction

   function automatic logic [8:0] rlit();
      return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 12))};
   endfunction

   task automatic set_lane(input int addr, input int lane, input logic [8:0] a,
                           input logic [8:0] b, input logic [8:0] c, input logic [2:0] m);
      mem[addr % 1024][lane*LANE_W +: LANE_W] = {m, c, b, a};
   endtask

   task automatic fill_rand(input int base, input int beats);
      for (int b = 0; b < beats + 1; b++)
         for (int l = 0; l < 4; l++)
            set_lane(base + b, l, rlit(), rlit(), rlit(), 3'($urandom_range(0, 7)));
   endtask

   // Reference: walk the first n clauses in order and classify every
   // literal present in its clause mask.
   function automatic logic [255:0] ref_pure(input int n, input int base);
      logic [255:0] p, q;
      p = '0;
      q = '0;
      for (int i = 0; i < n; i++) begin
         logic [BEAT_W-1:0] bw;
         logic [LANE_W-1:0] lw;
         logic [8:0]        li;
         bw = mem[(base + i/4) % 1024];
         lw = bw[(i%4)*LANE_W +: LANE_W];
         for (int k = 0; k < 3; k++) begin
            if (lw[27+k]) begin
               li = lw[k*9 +: 9];
               if (li[8]) q[li[7:0]] = 1'b1;
               else       p[li[7:0]] = 1'b1;
            end
         end
      end
      return (p & ~q) | (q & ~p);
   endfunction

   task automatic check_reset_vals(input string name);
      check({name, "_rst_ctl"}, {busy, done, mem_rd_en, result_valid}, 4'b0000);
      check({name, "_rst_addr"}, mem_rd_addr, 0);
      check({name, "_rst_result"}, result, 0);
      check({name, "_rst_count"}, pure_count, 0);
      check({name, "_rst_reduced"}, dp_reduced, 0);
      check({name, "_rst_clear"}, dp_clear, 1);
   endtask

   task automatic wait_quiet(input string name);
      int dn = 0;
      int bz = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) dn++;
         if (busy) bz++;
      end
      check({name, "_no_done"}, dn, 0);
      check({name, "_no_busy"}, bz, 0);
      check({name, "_rv_low"}, result_valid, 0);
   endtask

   // ev_kind: 0 none, 1 abort at ev_cyc, 2 extra start at ev_cyc, 3 reset at ev_cyc.
   task automatic run_scan(input string name, input int n, input int base,
                           input int ev_kind, input int ev_cyc, output logic [255:0] res_o);
      int nb = (n + 3) / 4;
      int issues = 0;
      int viol = 0;
      int done_c = -1;
      int prev_beat = -1;
      logic [255:0] expv;
      expv  = ref_pure(n, base);
      res_o = '0;
      @(negedge clk);
      start       = 1'b1;
      num_clauses = CNT_W'(n);
      base_addr   = ADDR_W'(base);
      for (int c = 1; c <= nb + 20; c++) begin
         int cur_beat = -1;
         @(negedge clk);
         if (c == 1) start = 1'b0;
         if (ev_kind == 2 && c == ev_cyc) begin
            start       = 1'b1;
            num_clauses = CNT_W'($urandom_range(0, 40));
            base_addr   = ADDR_W'($urandom_range(0, 1023));
         end
         if (ev_kind == 2 && c == ev_cyc + 1) start = 1'b0;
         if (ev_kind == 1 && c == ev_cyc) begin
            abort = 1'b1;
            #1;
            check({name, "_abort_rd_en"}, mem_rd_en, 0);
            @(negedge clk);
            abort = 1'b0;
            check({name, "_abort_idle"}, busy, 0);
            check({name, "_abort_trail"}, dp_reduced, 0);
            wait_quiet(name);
            return;
         end
         if (ev_kind == 3 && c == ev_cyc) begin
            reset = 1'b1;
            #1;
            check({name, "_rst_clear_during"}, dp_clear, 1);
            @(negedge clk);
            check_reset_vals(name);
            reset = 1'b0;
            wait_quiet(name);
            return;
         end
         if (mem_rd_en) begin
            if (mem_rd_addr != ADDR_W'((base + issues) % 1024)) viol++;
            if (c < 2 || c > nb + 1) viol++;
            cur_beat = issues;
            issues++;
         end else if (c >= 2 && c <= nb + 1) begin
            viol++;
         end
         for (int l = 0; l < 4; l++) begin
            logic [2:0]        el;
            logic [BEAT_W-1:0] bw;
            el = '0;
            if (prev_beat >= 0 && 4*prev_beat + l < n) begin
               bw = mem[(base + prev_beat) % 1024];
               el = bw[l*LANE_W + 27 +: 3];
            end
            if (dp_reduced[l*3 +: 3] != el) viol++;
         end
         if (busy != (c <= nb + 4)) viol++;
         if (dp_clear != (c == 1)) viol++;
         if (c <= nb + 4 && result_valid) viol++;
         prev_beat = cur_beat;
         if (done) begin
            done_c = c;
            break;
         end
      end
      res_o = result;
      check({name, "_done_cycle"}, done_c, nb + 5);
      check({name, "_issues"}, issues, nb);
      check({name, "_cycle_viol"}, viol, 0);
      check({name, "_result"}, result, expv);
      check({name, "_count"}, pure_count, $countones(expv));
      check({name, "_rv"}, result_valid, 1);
      @(negedge clk);
      check({name, "_after"}, {done, busy, result_valid}, 3'b001);
   endtask

   initial begin
      logic [255:0] r;
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      num_clauses = '0; base_addr = '0;
      for (int a = 0; a < 1024; a++) mem[a] = '0;
      repeat (3) @(negedge clk);
      check_reset_vals("init");
      reset = 1'b0;

      // x1 only positive, x2 both polarities, x3 only negative
      set_lane(0, 0, lit(1, 0), lit(2, 0), lit(3, 1), 3'b111);
      set_lane(0, 1, lit(1, 0), lit(2, 1), lit(3, 1), 3'b111);
      set_lane(0, 2, lit(1, 0), lit(2, 0), lit(3, 1), 3'b111);
      set_lane(0, 3, lit(1, 0), lit(2, 1), lit(3, 1), 3'b111);
      run_scan("t1", 4, 0, 0, 0, r);
      check("t1_bits", r[3:0], 4'b1010);

      // second beat: only lane 0 valid, lanes 1..3 carry -x1
      for (int l = 0; l < 4; l++) set_lane(100, l, lit(1, 0), lit(1, 0), lit(1, 0), 3'b111);
      set_lane(101, 0, lit(1, 0), lit(1, 0), lit(1, 0), 3'b111);
      for (int l = 1; l < 4; l++) set_lane(101, l, lit(1, 1), lit(1, 1), lit(1, 1), 3'b111);
      run_scan("t2", 5, 100, 0, 0, r);
      check("t2_x1_pure", r[1], 1);

      run_scan("t3_empty", 0, 200, 0, 0, r);

      fill_rand(1023, 3);
      run_scan("t4_wrap", 11, 1023, 0, 0, r);

      fill_rand(300, 4);
      run_scan("t5_abort", 16, 300, 1, 3, r);
      fill_rand(400, 4);
      run_scan("t5_after", 14, 400, 0, 0, r);

      fill_rand(500, 5);
      run_scan("t6_restart", 20, 500, 2, 4, r);

      fill_rand(600, 3);
      run_scan("t7_reset", 12, 600, 3, 6, r);

      for (int t = 0; t < 6; t++) begin
         int n;
         int b;
         n = $urandom_range(0, 40);
         b = $urandom_range(0, 1023);
         fill_rand(b, (n + 3) / 4);
         run_scan($sformatf("rnd%0d", t), n, b, 0, 0, r);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
